sm_key_debouncer: RTL and testbench

Input-conditioning stage sitting between the board push-buttons and the board top's consumers (CPU clock enable, register-address select, display control). Each raw, asynchronous, bouncing key input is synchronized into the `clkIn` domain and filtered by a per-key stability counter. The block outputs a clean debounced level, single-cycle press/release pulses, and a press-toggled latch per key. All keys are independent; one instance serves the whole key bank.

---
 rtl/sm_key_debouncer.sv | 93 +++++++++
 tb/tb_sm_key_debouncer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_key_debouncer.sv
// Key-bank conditioner: two-flop synchronizer, per-key stability counter,
// and registered level, press/release pulses and a press-toggled latch.
module sm_key_debouncer #(
    parameter int WIDTH      = 4,
    parameter int DEBOUNCE   = 50000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic             clkIn,
    input  logic             rst,
    input  logic [WIDTH-1:0] keyIn,
    output logic [WIDTH-1:0] keyState,
    output logic [WIDTH-1:0] keyPress,
    output logic [WIDTH-1:0] keyRelease,
    output logic [WIDTH-1:0] keyToggle
);

    localparam int               CNT_W   = $clog2(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

    logic [WIDTH-1:0] norm;
    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] press_q, press_d;
    logic [WIDTH-1:0] release_q, release_d;
    logic [WIDTH-1:0] toggle_q, toggle_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // Internally 1 always means pressed, whatever the board polarity.
    assign norm = (ACTIVE_LOW != 0) ? ~keyIn : keyIn;

    // Synchronizer stage boundary
    always_comb begin
        sync1_d = norm;
        sync2_d = sync1_q;
    end

    // Stability filter and event stage boundary
    always_comb begin
        stable_d  = stable_q;
        toggle_d  = toggle_q;
        press_d   = '0;
        release_d = '0;
        cnt_d     = cnt_q;
        for (int k = 0; k < WIDTH; k++) begin
            if (sync2_q[k] == stable_q[k]) begin
                cnt_d[k] = '0;
            end else if (cnt_q[k] != CNT_MAX) begin
                cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end else begin
                stable_d[k]  = sync2_q[k];
                cnt_d[k]     = '0;
                press_d[k]   = sync2_q[k];
                release_d[k] = ~sync2_q[k];
                if (sync2_q[k]) begin
                    toggle_d[k] = ~toggle_q[k];
                end
            end
        end
    end

    // Reset clears the synchronizer to "released" so a held key re-presses.
    always_ff @(posedge clkIn) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            press_q   <= '0;
            release_q <= '0;
            toggle_q  <= '0;
            for (int k = 0; k < WIDTH; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            stable_q  <= stable_d;
            press_q   <= press_d;
            release_q <= release_d;
            toggle_q  <= toggle_d;
            for (int k = 0; k < WIDTH; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign keyState   = stable_q;
    assign keyPress   = press_q;
    assign keyRelease = release_q;
    assign keyToggle  = toggle_q;

endmodule

// File: tb/tb_sm_key_debouncer.sv
// Bench for sm_key_debouncer: directed scenarios plus randomized key traffic,
// checked against a history-window model of the debounce rule.
module tb_sm_key_debouncer;

    localparam int W  = 4;
    localparam int D  = 4;
    localparam int AL = 1;

    logic         clkIn = 1'b0;
    logic         rst   = 1'b1;
    logic [W-1:0] keyIn = '0;
    logic [W-1:0] keyState, keyPress, keyRelease, keyToggle;

    int n_checks = 0;
    int n_pass   = 0;

    sm_key_debouncer #(.WIDTH(W), .DEBOUNCE(D), .ACTIVE_LOW(AL)) dut (
        .clkIn     (clkIn),
        .rst       (rst),
        .keyIn     (keyIn),
        .keyState  (keyState),
        .keyPress  (keyPress),
        .keyRelease(keyRelease),
        .keyToggle (keyToggle)
    );

    always #5 clkIn = ~clkIn;

    // Reference model: a key is accepted when the synchronized level seen at the
    // last D edges all disagree with the current stable level.
    logic [W-1:0] m_state = '0, m_press = '0, m_rel = '0, m_tog = '0;
    logic [W-1:0] m_d1 = '0, m_d2 = '0;
    logic [W-1:0] s2_hist[$];

    task automatic model_step();
        logic [W-1:0] seen;
        bit accept;
        if (rst) begin
            m_state = '0; m_press = '0; m_rel = '0; m_tog = '0;
            m_d1 = '0; m_d2 = '0;
            s2_hist.delete();
        end else begin
            seen = m_d2;
            m_d2 = m_d1;
            m_d1 = (AL != 0) ? ~keyIn : keyIn;
            s2_hist.push_back(seen);
            if (s2_hist.size() > D) void'(s2_hist.pop_front());
            m_press = '0;
            m_rel   = '0;
            for (int k = 0; k < W; k++) begin
                accept = (s2_hist.size() == D);
                if (accept)
                    for (int j = 0; j < D; j++)
                        if (s2_hist[j][k] == m_state[k]) accept = 1'b0;
                if (accept) begin
                    m_state[k] = ~m_state[k];
                    if (m_state[k]) begin
                        m_press[k] = 1'b1;
                        m_tog[k]   = ~m_tog[k];
                    end else begin
                        m_rel[k] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clkIn);
        model_step();
        @(negedge clkIn);
    endtask

    task automatic test_reset();
        int press_edge;
        rst   = 1'b1;
        keyIn = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if ({keyState, keyPress, keyRelease, keyToggle} !== 16'h0000)
                $display("FAIL reset_hold cyc=%0d got=%h expected=0000", i,
                         {keyState, keyPress, keyRelease, keyToggle});
            else n_pass++;
        end
        rst = 1'b0;
        press_edge = -1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_checks++;
            if ({keyState, keyPress, keyRelease, keyToggle} !== {m_state, m_press, m_rel, m_tog})
                $display("FAIL reset_release edge=%0d got=%h expected=%h", i,
                         {keyState, keyPress, keyRelease, keyToggle}, {m_state, m_press, m_rel, m_tog});
            else n_pass++;
            if (keyPress == 4'hF && press_edge < 0) press_edge = i;
        end
        n_checks++;
        if (press_edge !== 6) $display("FAIL reset_press_latency got=%0d expected=6", press_edge);
        else n_pass++;
        n_checks++;
        if (keyState !== 4'hF) $display("FAIL reset_state got=%b expected=1111", keyState);
        else n_pass++;
    endtask

    task automatic test_clean_press();
        int ev_edge;
        rst = 1'b1; keyIn = 4'hF;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        for (int phase = 0; phase < 2; phase++) begin
            keyIn[0] = (phase == 1);
            ev_edge = -1;
            for (int i = 1; i <= 10; i++) begin
                tick();
                n_checks++;
                if ({keyState, keyPress, keyRelease, keyToggle} !== {m_state, m_press, m_rel, m_tog})
                    $display("FAIL clean_press ph=%0d edge=%0d got=%h expected=%h", phase, i,
                             {keyState, keyPress, keyRelease, keyToggle}, {m_state, m_press, m_rel, m_tog});
                else n_pass++;
                if (ev_edge < 0 && (phase == 0 ? keyPress[0] : keyRelease[0]) === 1'b1) ev_edge = i;
            end
            n_checks++;
            if (ev_edge !== 6) $display("FAIL clean_latency ph=%0d got=%0d expected=6", phase, ev_edge);
            else n_pass++;
            n_checks++;
            if (keyToggle[0] !== 1'b1) $display("FAIL clean_toggle ph=%0d got=%b expected=1", phase, keyToggle[0]);
            else n_pass++;
        end
    endtask

    task automatic test_bounce();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            keyIn[1] = !(i < 3 || (i >= 4 && i < 7));
            tick();
            n_checks++;
            if ({keyState, keyPress, keyRelease, keyToggle} !== {m_state, m_press, m_rel, m_tog})
                $display("FAIL bounce_short cyc=%0d got=%h expected=%h", i,
                         {keyState, keyPress, keyRelease, keyToggle}, {m_state, m_press, m_rel, m_tog});
            else n_pass++;
            pulses += int'(keyPress[1]) + int'(keyRelease[1]);
        end
        n_checks++;
        if (pulses !== 0 || keyState[1] !== 1'b0)
            $display("FAIL bounce_reject got pulses=%0d state=%b expected pulses=0 state=0", pulses, keyState[1]);
        else n_pass++;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            keyIn[1] = (i == 4);
            tick();
            n_checks++;
            if ({keyState, keyPress, keyRelease, keyToggle} !== {m_state, m_press, m_rel, m_tog})
                $display("FAIL bounce_long cyc=%0d got=%h expected=%h", i,
                         {keyState, keyPress, keyRelease, keyToggle}, {m_state, m_press, m_rel, m_tog});
            else n_pass++;
            pulses += int'(keyPress[1]);
        end
        n_checks++;
        if (pulses !== 1 || keyState[1] !== 1'b1)
            $display("FAIL bounce_accept got presses=%0d state=%b expected presses=1 state=1", pulses, keyState[1]);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        logic [1:0] st_lo, tg_lo, ev_lo;
        int e2, e3;
        st_lo = keyState[1:0];
        tg_lo = keyToggle[1:0];
        ev_lo = '0;
        e2 = -1; e3 = -1;
        keyIn[3:2] = 2'b00;
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_checks++;
            if ({keyState, keyPress, keyRelease, keyToggle} !== {m_state, m_press, m_rel, m_tog})
                $display("FAIL simul edge=%0d got=%h expected=%h", i,
                         {keyState, keyPress, keyRelease, keyToggle}, {m_state, m_press, m_rel, m_tog});
            else n_pass++;
            if (e2 < 0 && keyPress[2]) e2 = i;
            if (e3 < 0 && keyPress[3]) e3 = i;
            ev_lo |= keyPress[1:0] | keyRelease[1:0];
        end
        n_checks++;
        if (e2 !== 6 || e3 !== 6) $display("FAIL simul_latency got e2=%0d e3=%0d expected 6 6", e2, e3);
        else n_pass++;
        n_checks++;
        if (keyState[1:0] !== st_lo || keyToggle[1:0] !== tg_lo || ev_lo !== 2'b00)
            $display("FAIL simul_isolation got st=%b tg=%b ev=%b expected st=%b tg=%b ev=00",
                     keyState[1:0], keyToggle[1:0], ev_lo, st_lo, tg_lo);
        else n_pass++;
    endtask

    task automatic test_reset_mid_count();
        int pe;
        keyIn[0] = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (keyState !== 4'h0 || keyPress !== 4'h0)
            $display("FAIL midrst_clear got st=%b pr=%b expected 0000 0000", keyState, keyPress);
        else n_pass++;
        pe = -1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_checks++;
            if ({keyState, keyPress, keyRelease, keyToggle} !== {m_state, m_press, m_rel, m_tog})
                $display("FAIL midrst edge=%0d got=%h expected=%h", i,
                         {keyState, keyPress, keyRelease, keyToggle}, {m_state, m_press, m_rel, m_tog});
            else n_pass++;
            if (pe < 0 && keyPress[0]) pe = i;
        end
        n_checks++;
        if (pe !== 6) $display("FAIL midrst_latency got=%0d expected=6", pe);
        else n_pass++;
    endtask

    task automatic test_toggle();
        logic [2:0] tg_seen;
        int np, nr;
        np = 0; nr = 0;
        rst = 1'b1; keyIn = 4'hF;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        for (int p = 0; p < 3; p++) begin
            for (int half = 0; half < 2; half++) begin
                keyIn[3] = (half == 1);
                for (int i = 0; i < 8; i++) begin
                    tick();
                    n_checks++;
                    if ({keyState, keyPress, keyRelease, keyToggle} !== {m_state, m_press, m_rel, m_tog})
                        $display("FAIL toggle p=%0d h=%0d cyc=%0d got=%h expected=%h", p, half, i,
                                 {keyState, keyPress, keyRelease, keyToggle}, {m_state, m_press, m_rel, m_tog});
                    else n_pass++;
                    np += int'(keyPress[3]);
                    nr += int'(keyRelease[3]);
                end
                if (half == 0) tg_seen[p] = keyToggle[3];
            end
        end
        n_checks++;
        if (tg_seen !== 3'b101) $display("FAIL toggle_seq got=%b expected=101 (p2,p1,p0)", tg_seen);
        else n_pass++;
        n_checks++;
        if (np !== 3 || nr !== 3) $display("FAIL toggle_counts got press=%0d release=%0d expected 3 3", np, nr);
        else n_pass++;
    endtask

    task automatic test_random();
        int hold[W];
        for (int k = 0; k < W; k++) hold[k] = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < W; k++) begin
                if (hold[k] == 0) begin
                    keyIn[k] = 1'($urandom_range(0, 1));
                    hold[k]  = $urandom_range(1, 7);
                end
                hold[k]--;
            end
            rst = ($urandom_range(0, 199) == 0);
            tick();
            n_checks++;
            if ({keyState, keyPress, keyRelease, keyToggle} !== {m_state, m_press, m_rel, m_tog})
                $display("FAIL random cyc=%0d got=%h expected=%h", c,
                         {keyState, keyPress, keyRelease, keyToggle}, {m_state, m_press, m_rel, m_tog});
            else n_pass++;
            n_checks++;
            if ((keyPress & keyRelease) !== 4'h0)
                $display("FAIL random_exclusive cyc=%0d got=%b expected=0000", c, keyPress & keyRelease);
            else n_pass++;
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_reset_mid_count();
        test_toggle();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
